// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath sizes and immediate-extension encodings.
// Pure declarations, no logic, no latency, no flow control.
package cpu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'd0,
        EXT_ZERO  = 2'd1,
        EXT_UPPER = 2'd2,
        EXT_RSVD  = 2'd3
    } ext_op_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard and outstanding-load counter; hazard and ready are combinational from registered state.
// Issue is backpressured by ld_count reaching MAX_LD or any hazard; responses are always taken outside reset.
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int MAX_LD = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs_addr,
    input  logic            rs_used,
    input  logic [AW-1:0]   rt_addr,
    input  logic            rt_used,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            iss_vld,
    input  logic [AW-1:0]   iss_addr,
    input  logic            rsp_vld,
    input  logic [AW-1:0]   rsp_addr,
    output logic            iss_rdy,
    output logic            hazard_stall,
    output logic            rsp_commit,
    output logic            wr_commit,
    output logic [NREG-1:0] busy_vec,
    output logic [3:0]      ld_count,
    output logic            err_sticky
);

    logic [NREG-1:0] busy_d;
    logic [3:0]      count_d;
    logic            iss_fire;
    logic            iss_nz;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            wr_drop;

    assign hazard_stall = (rs_used && busy_vec[rs_addr]) ||
                          (rt_used && busy_vec[rt_addr]) ||
                          (wr_en   && busy_vec[wr_addr]);

    assign iss_rdy    = !reset && (ld_count < 4'(MAX_LD)) && !hazard_stall;
    assign iss_fire   = iss_vld && iss_rdy;
    assign iss_nz     = iss_fire && (iss_addr != '0);
    assign rsp_fire   = rsp_vld && !reset;
    assign rsp_commit = rsp_fire && (rsp_addr != '0) && busy_vec[rsp_addr];
    assign rsp_drop   = rsp_fire && !rsp_commit;
    // busy_vec[0] is never set, so this also rejects r0 for the busy check
    assign wr_commit  = wr_en && (wr_addr != '0) && !busy_vec[wr_addr];
    assign wr_drop    = wr_en && busy_vec[wr_addr];

    // A re-issue to the register being answered keeps it busy and nets the count to zero change
    always_comb begin
        busy_d  = busy_vec;
        count_d = ld_count;
        if (rsp_commit) busy_d[rsp_addr] = 1'b0;
        if (iss_nz)     busy_d[iss_addr] = 1'b1;
        if (iss_nz && !rsp_commit && (ld_count < 4'(MAX_LD)))
            count_d = ld_count + 4'd1;
        else if (rsp_commit && !iss_nz && (ld_count != 4'd0))
            count_d = ld_count - 4'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_vec   <= '0;
            ld_count   <= '0;
            err_sticky <= 1'b0;
        end else begin
            busy_vec   <= busy_d;
            ld_count   <= count_d;
            if (rsp_drop || wr_drop) err_sticky <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write/load-response bypass, immediate extender and load scoreboard; reads are combinational.
// Writes commit at the next edge; load issue stalls on hazards or a full load window, responses never stall.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int MAX_LD = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs_addr,
    input  logic [AW-1:0]   rt_addr,
    input  logic            rs_used,
    input  logic            rt_used,
    output logic [XLEN-1:0] rs_data,
    output logic [XLEN-1:0] rt_data,
    input  logic [15:0]     imm_in,
    input  logic [1:0]      ext_op,
    output logic [XLEN-1:0] imm_out,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            ld_issue_valid,
    input  logic [AW-1:0]   ld_issue_addr,
    output logic            ld_issue_ready,
    input  logic            ld_resp_valid,
    input  logic [AW-1:0]   ld_resp_addr,
    input  logic [XLEN-1:0] ld_resp_data,
    output logic            ld_resp_ready,
    output logic            hazard_stall,
    output logic [NREG-1:0] busy_vec,
    output logic [3:0]      ld_count,
    output logic            err_sticky
);

    logic [XLEN-1:0] rf [NREG];
    logic            rsp_commit;
    logic            wr_commit;

    assign ld_resp_ready = !reset;

    rf_scoreboard #(.NREG(NREG), .MAX_LD(MAX_LD)) u_sb (
        .clock        (clock),
        .reset        (reset),
        .rs_addr      (rs_addr),
        .rs_used      (rs_used),
        .rt_addr      (rt_addr),
        .rt_used      (rt_used),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .iss_vld      (ld_issue_valid),
        .iss_addr     (ld_issue_addr),
        .rsp_vld      (ld_resp_valid),
        .rsp_addr     (ld_resp_addr),
        .iss_rdy      (ld_issue_ready),
        .hazard_stall (hazard_stall),
        .rsp_commit   (rsp_commit),
        .wr_commit    (wr_commit),
        .busy_vec     (busy_vec),
        .ld_count     (ld_count),
        .err_sticky   (err_sticky)
    );

    // Both writes can land together: wr_commit is blocked on busy registers, so addresses never collide
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (rsp_commit) rf[ld_resp_addr] <= ld_resp_data;
            if (wr_commit)  rf[wr_addr]      <= wr_data;
        end
    end

    assign rs_data = (rs_addr == '0)                           ? '0           :
                     (rsp_commit && (ld_resp_addr == rs_addr)) ? ld_resp_data :
                     (wr_commit  && (wr_addr == rs_addr))      ? wr_data      :
                                                                 rf[rs_addr];

    assign rt_data = (rt_addr == '0)                           ? '0           :
                     (rsp_commit && (ld_resp_addr == rt_addr)) ? ld_resp_data :
                     (wr_commit  && (wr_addr == rt_addr))      ? wr_data      :
                                                                 rf[rt_addr];

    always_comb begin
        imm_out = '0;
        case (ext_op_e'(ext_op))
            EXT_SIGN:  imm_out = {{(XLEN-16){imm_in[15]}}, imm_in};
            EXT_ZERO:  imm_out = {{(XLEN-16){1'b0}}, imm_in};
            EXT_UPPER: imm_out = XLEN'(imm_in) << 16;
            default:   imm_out = '0;
        endcase
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr;
    logic        rs_used, rt_used;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm_in;
    logic [1:0]  ext_op;
    logic [31:0] imm_out;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_addr;
    logic        ld_issue_ready;
    logic        ld_resp_valid;
    logic [4:0]  ld_resp_addr;
    logic [31:0] ld_resp_data;
    logic        ld_resp_ready;
    logic        hazard_stall;
    logic [31:0] busy_vec;
    logic [3:0]  ld_count;
    logic        err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    regfile_scoreboard #(.XLEN(32), .NREG(32), .MAX_LD(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_used        (rs_used),
        .rt_used        (rt_used),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .imm_in         (imm_in),
        .ext_op         (ext_op),
        .imm_out        (imm_out),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_addr  (ld_issue_addr),
        .ld_issue_ready (ld_issue_ready),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_addr   (ld_resp_addr),
        .ld_resp_data   (ld_resp_data),
        .ld_resp_ready  (ld_resp_ready),
        .hazard_stall   (hazard_stall),
        .busy_vec       (busy_vec),
        .ld_count       (ld_count),
        .err_sticky     (err_sticky)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs settle 1ns after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        wr_en = 0; ld_issue_valid = 0; ld_resp_valid = 0;
        rs_used = 0; rt_used = 0;
    endtask

    initial begin
        reset = 1; idle();
        rs_addr = 0; rt_addr = 0; wr_addr = 0; wr_data = 0;
        ld_issue_addr = 0; ld_resp_addr = 0; ld_resp_data = 0;
        imm_in = 0; ext_op = 0;

        // Response arriving mid-reset must be refused and not flagged
        ld_resp_valid = 1; ld_resp_addr = 5; ld_resp_data = 32'hAAAA;
        ld_issue_valid = 1; ld_issue_addr = 6;
        settle();
        chk("rst_resp_ready", {31'd0, ld_resp_ready}, 32'd0);
        chk("rst_issue_ready", {31'd0, ld_issue_ready}, 32'd0);
        tick(); tick();
        reset = 0; idle();
        settle();
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_count", {28'd0, ld_count}, 32'd0);
        chk("rst_err", {31'd0, err_sticky}, 32'd0);
        chk("rst_resp_ready_hi", {31'd0, ld_resp_ready}, 32'd1);
        rs_addr = 31; rt_addr = 5;
        settle();
        chk("rst_r31", rs_data, 32'd0);
        chk("rst_r5", rt_data, 32'd0);

        // Plain write then array read
        wr_en = 1; wr_addr = 5; wr_data = 32'h1234;
        tick();
        wr_en = 0; rs_addr = 5; rs_used = 1;
        settle();
        chk("wr_r5", rs_data, 32'h1234);

        // Same-cycle write bypass to rt
        wr_en = 1; wr_addr = 7; wr_data = 32'hDEAD; rt_addr = 7;
        settle();
        chk("byp_r7", rt_data, 32'hDEAD);
        tick();
        wr_en = 0;
        settle();
        chk("arr_r7", rt_data, 32'hDEAD);

        // r0 stays zero
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF; rs_addr = 0;
        settle();
        chk("r0_byp", rs_data, 32'd0);
        tick();
        wr_en = 0;
        settle();
        chk("r0_arr", rs_data, 32'd0);

        // Load to r9: hazard, then response bypass and clear
        idle();
        ld_issue_valid = 1; ld_issue_addr = 9;
        settle();
        chk("iss9_ready", {31'd0, ld_issue_ready}, 32'd1);
        tick();
        ld_issue_valid = 0;
        rs_addr = 9; rs_used = 1;
        settle();
        chk("iss9_busy", busy_vec, 32'h0000_0200);
        chk("iss9_count", {28'd0, ld_count}, 32'd1);
        chk("iss9_hazard", {31'd0, hazard_stall}, 32'd1);
        chk("iss9_ready_lo", {31'd0, ld_issue_ready}, 32'd0);
        ld_resp_valid = 1; ld_resp_addr = 9; ld_resp_data = 32'hBEEF;
        settle();
        chk("rsp9_byp", rs_data, 32'hBEEF);
        tick();
        ld_resp_valid = 0;
        settle();
        chk("rsp9_stall", {31'd0, hazard_stall}, 32'd0);
        chk("rsp9_count", {28'd0, ld_count}, 32'd0);
        chk("rsp9_arr", rs_data, 32'hBEEF);
        chk("rsp9_err", {31'd0, err_sticky}, 32'd0);

        // Fill the load window with r1..r4
        idle();
        for (int i = 1; i <= 4; i++) begin
            ld_issue_valid = 1; ld_issue_addr = 5'(i);
            tick();
        end
        ld_issue_valid = 0;
        settle();
        chk("win_count", {28'd0, ld_count}, 32'd4);
        chk("win_ready", {31'd0, ld_issue_ready}, 32'd0);
        chk("win_busy", busy_vec, 32'h0000_001E);
        ld_resp_valid = 1; ld_resp_addr = 1; ld_resp_data = 32'h11;
        tick();
        ld_resp_valid = 0;
        settle();
        chk("win_count3", {28'd0, ld_count}, 32'd3);
        chk("win_ready_hi", {31'd0, ld_issue_ready}, 32'd1);

        // WAW: write to busy r3 is dropped and flagged
        wr_en = 1; wr_addr = 3; wr_data = 32'h3333;
        settle();
        chk("waw_hazard", {31'd0, hazard_stall}, 32'd1);
        tick();
        wr_en = 0; rs_addr = 3; rs_used = 0;
        settle();
        chk("waw_r3", rs_data, 32'd0);
        chk("waw_err", {31'd0, err_sticky}, 32'd1);

        // Reset discards outstanding loads and the error flag
        reset = 1;
        tick();
        reset = 0;
        settle();
        chk("rst2_busy", busy_vec, 32'd0);
        chk("rst2_err", {31'd0, err_sticky}, 32'd0);
        chk("rst2_r5", rt_data, 32'd0);

        // Response to non-busy r12 is dropped and flagged
        ld_resp_valid = 1; ld_resp_addr = 12; ld_resp_data = 32'h5555; rs_addr = 12;
        settle();
        chk("nb_byp", rs_data, 32'd0);
        tick();
        ld_resp_valid = 0;
        settle();
        chk("nb_r12", rs_data, 32'd0);
        chk("nb_err", {31'd0, err_sticky}, 32'd1);
        chk("nb_count", {28'd0, ld_count}, 32'd0);

        // Same-cycle issue and response to r6
        ld_issue_valid = 1; ld_issue_addr = 6;
        tick();
        ld_resp_valid = 1; ld_resp_addr = 6; ld_resp_data = 32'h66;
        tick();
        ld_issue_valid = 0; ld_resp_valid = 0; rs_addr = 6;
        settle();
        chk("ir_busy", busy_vec, 32'h0000_0040);
        chk("ir_count", {28'd0, ld_count}, 32'd1);
        chk("ir_r6", rs_data, 32'h66);

        // Same-cycle wr_en r8 and response r6 both commit
        wr_en = 1; wr_addr = 8; wr_data = 32'h88;
        ld_resp_valid = 1; ld_resp_addr = 6; ld_resp_data = 32'h77;
        tick();
        idle();
        rs_addr = 6; rt_addr = 8;
        settle();
        chk("dual_r6", rs_data, 32'h77);
        chk("dual_r8", rt_data, 32'h88);
        chk("dual_count", {28'd0, ld_count}, 32'd0);

        // Immediate extension
        imm_in = 16'h8001;
        ext_op = 0; settle(); chk("imm_sign", imm_out, 32'hFFFF_8001);
        ext_op = 1; settle(); chk("imm_zero", imm_out, 32'h0000_8001);
        ext_op = 2; settle(); chk("imm_upper", imm_out, 32'h8001_0000);
        ext_op = 3; settle(); chk("imm_rsvd", imm_out, 32'd0);
        imm_in = 16'h7FFF;
        ext_op = 0; settle(); chk("imm_sign_pos", imm_out, 32'h0000_7FFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32: register and data width.
REQ-002 SHALL have parameter NREG, default 32: register count, a power of 2; AW = log2(NREG).
REQ-003 SHALL have parameter MAX_LD, default 4: maximum outstanding loads, 1..15.
REQ-004 SHALL have ports clock (in, 1, rising-edge clock) and reset (in, 1, reset, synchronous, active-high), listed first.
REQ-005 SHALL have read ports rs_addr and rt_addr (in, AW each) and rs_used and rt_used (in, 1 each): operand addresses and their use flags.
REQ-006 SHALL have rs_data and rt_data (out, XLEN each): operand values.
REQ-007 SHALL have imm_in (in, 16), ext_op (in, 2: 0=sign, 1=zero, 2=upper, 3=reserved) and imm_out (out, XLEN).
REQ-008 SHALL have a writeback port: wr_en (in, 1), wr_addr (in, AW), wr_data (in, XLEN).
REQ-009 SHALL have a load-issue port: ld_issue_valid (in, 1), ld_issue_addr (in, AW), ld_issue_ready (out, 1).
REQ-010 SHALL have a load-response port: ld_resp_valid (in, 1), ld_resp_addr (in, AW), ld_resp_data (in, XLEN), ld_resp_ready (out, 1).
REQ-011 SHALL have status outputs: hazard_stall (out, 1), busy_vec (out, NREG), ld_count (out, 4), err_sticky (out, 1).

Function
REQ-012 SHALL read rs_data and rt_data combinationally; register 0 SHALL always read 0.
REQ-013 SHALL bypass same-cycle writes to the read ports; priority is load-response data, then wr_data, then array contents.
REQ-014 SHALL commit writes on the rising edge; the array SHALL be readable without bypass one cycle after the write.
REQ-015 SHALL ignore every write to register 0.
REQ-016 SHALL form imm_out combinationally: sign-extend imm_in for ext_op=0, zero-extend for 1, {imm_in, zeros} for 2, and 0 for 3.
REQ-017 SHALL accept a load issue on ld_issue_valid AND ld_issue_ready, where ld_issue_ready = (ld_count < MAX_LD) AND NOT hazard_stall.
REQ-018 On an accepted issue to a non-zero address, SHALL set busy_vec[addr] and increment ld_count at the next edge.
REQ-019 SHALL complete an issue to address 0 without setting busy or changing ld_count.
REQ-020 SHALL hold ld_resp_ready = 1 whenever reset is low.
REQ-021 On a response to a busy register, SHALL write ld_resp_data, clear busy and decrement ld_count.
REQ-022 SHALL drop a response to a non-busy register or to register 0 (no write), set err_sticky, and leave ld_count unchanged.
REQ-023 SHALL assert hazard_stall combinationally when (rs_used AND busy[rs_addr]) OR (rt_used AND busy[rt_addr]) OR (wr_en AND busy[wr_addr]), evaluated before the same-cycle response clears busy.
REQ-024 SHALL discard wr_en to a busy register (WAW protection) and set err_sticky.
REQ-025 On a same-cycle issue and response to the same address, SHALL write the data, leave busy set, and leave ld_count unchanged.
REQ-026 On a same-cycle wr_en and response to different addresses, SHALL commit both writes.
REQ-027 SHALL keep ld_count saturating within 0..MAX_LD, with no wrap-around.

Reset
REQ-028 While reset is high at an edge, SHALL clear all NREG registers, busy_vec, ld_count and err_sticky to 0.
REQ-029 SHALL drive ld_resp_ready = 0 and ld_issue_ready = 0 during reset, and SHALL discard a response arriving mid-reset.
REQ-030 SHALL discard outstanding loads on reset and SHALL NOT flag any later response for them beyond REQ-022.

Structure
REQ-031 SHALL place the ext_op encodings and the XLEN and NREG defaults in the shared package cpu_pkg.
REQ-032 SHALL implement busy-bit tracking and ld_count in one sub-module, rf_scoreboard; the array, bypass and extension logic stay in the top.

Verification
REQ-033 Bench SHALL cover: reset, write r5=0x1234 -> the next cycle rs_addr=5 gives 0x1234; with rs_addr=31 after reset -> 0.
REQ-034 Bench SHALL cover: wr_en r7=0xDEAD with rt_addr=7 in the same cycle -> rt_data=0xDEAD (bypass); a write to r0 -> r0 still reads 0.
REQ-035 Bench SHALL cover: issue load r9, then rs_addr=9 with rs_used=1 -> hazard_stall=1; response 0xBEEF -> stall=0, the response-cycle bypass gives 0xBEEF, and ld_count returns to 0.
REQ-036 Bench SHALL cover: issue 4 loads to r1..r4 -> ld_count=4 and ld_issue_ready=0; one response -> ld_issue_ready=1.
REQ-037 Bench SHALL cover: a response to non-busy r12 -> r12 unchanged and err_sticky=1; wr_en to busy r3 -> write dropped and err_sticky=1.
REQ-038 Bench SHALL cover: imm_in=0x8001 -> ext_op 0 gives 0xFFFF8001, 1 gives 0x00008001, 2 gives 0x80010000.
